tri_setup: RTL and testbench
============================

Name: tri_setup

Overview:
- Per-frame and per-line setup engine that drives the rasterizer's setup inputs.
- Latches four screen-space vertices and barycentric plane parameters once per frame, at the start of vertical blank.
- Computes the line-0 edge-function constants for two triangles with a shared sequential multiplier.
- Steps all per-line values incrementally during active video, so the rasterizer's load at x==799 always sees the values for the next line.

Parameters:
- H_ACTIVE, 640, first non-active x; the line step is issued at x==H_ACTIVE.
- V_ACTIVE, 480, first blank line; the frame latch occurs at (y==V_ACTIVE, x==0).
- C_W, 10, signed vertex coordinate width.
- E_W, 20, signed edge value width.
- B_W, 22, barycentric width (Q2.20).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- x  in  10  VGA column counter
- y  in  10  VGA row counter
- vx0..vx3  in  C_W each  signed vertex screen x
- vy0..vy3  in  C_W each  signed vertex screen y
- bar_iy0, bar_iz0, bar2_iy0, bar2_iz0  in  B_W each  barycentric values at (0,0)
- bar_iy_dy, bar_iz_dy, bar2_iy_dy, bar2_iz_dy  in  B_W each  per-line barycentric increments
- bar_iy_dx_in, bar_iz_dx_in, bar2_iy_dx_in, bar2_iz_dx_in  in  B_W each  per-pixel increments, latched per frame
- y_screen_v0..v3  out  E_W each  latched vy, sign-extended
- e0_init_t1, e1_init_t1, e2_init_t1, e0_init_t2, e1_init_t2, e2_init_t2  out  E_W each  edge values at (0, current line)
- bar_iy, bar_iz, bar2_iy, bar2_iz  out  B_W each  barycentrics at (0, current line)
- bar_iy_dx, bar_iz_dx, bar2_iy_dx, bar2_iz_dx  out  B_W each  latched per-pixel increments
- frame_ready  out  1  high when line-0 values are valid

Behaviour:
- Reset (rst_n low at a clk edge): every output is 0, frame_ready=0, FSM=IDLE, multiplier cleared.
- Edge list, (a,b):
  - t1: E0=(v0,v1), E1=(v1,v2), E2=(v2,v0).
  - t2: E0=(v0,v2), E1=(v2,v3), E2=(v3,v0).
- Per edge: dx=xb-xa, dy=yb-ya, computed 11-bit signed.
- Line-0 value: E(0,0) = -xa*dy + ya*dx, computed at 23 bits and saturated to E_W.
- Line step: E(0,y+1) = E(0,y) - dx, saturating.
- FSM states:
  - IDLE: on (y==V_ACTIVE, x==0), go to LATCH.
  - LATCH (1 cycle): capture all vertex and bar inputs; frame_ready<=0.
  - MUL: 12 products (2 per edge), signed radix-2 shift-add, 11 cycles each.
  - ACC: combine the pair, saturate, write the edge output (1 cycle per edge; a new product starts the following cycle).
  - LOAD: bar outputs<=*_0 inputs, dx outputs and y_screen outputs<=latched values; frame_ready<=1; go to IDLE.
  - Total ≤ 160 cycles, far below vblank (≥ 34,000 cycles).
- Line stepping: when y<V_ACTIVE and x==H_ACTIVE and frame_ready:
  - all 6 edge outputs step by -dx;
  - each bar output += its *_dy.
  - One step per line, so values for line y+1 are held from x==H_ACTIVE+1 through x==799.
- No stepping during vblank; line-0 values are held until the rasterizer's load at (524,799).
- Input changes outside LATCH are ignored.
- Outputs are only written in LOAD/ACC and on line steps; they are never written during MUL.
- Reset mid-MUL: abort; outputs 0 until the next frame latch completes.
- The first frame after reset renders a degenerate (all-zero) scene; this is acceptable.
- frame_ready=0 blocks stepping.
- Bar arithmetic wraps at B_W; edge arithmetic saturates at ±(2^(E_W-1)-1 / -2^(E_W-1)).

Decomposition:
- Package tri_setup_pkg:
  - H_ACTIVE and V_ACTIVE constants;
  - FSM state enum;
  - edge-index-to-vertex-pair table;
  - sat_e saturation function.
- One sub-module, seq_mul_s: signed start/busy/done shift-add multiplier, 10x11 -> 21 bits.

Test Plan:
- Triangle v0=(100,100), v1=(200,100), v2=(100,200): after LOAD, e0_init_t1=10000, e1_init_t1=-30000, e2_init_t1=10000, frame_ready=1.
- Same vertices, y=0 at x==640: next cycle e0_init_t1=9900, e1_init_t1=-29900, e2_init_t1=10000; values unchanged through x==799.
- bar_iy0=0x40000, bar_iy_dy=0x100, run lines 0..479: at x==700 of line y, bar_iy = 0x40000 + (y+1)*0x100; no change during vblank.
- Vertex inputs changed at y=200: outputs unaffected until the next (480,0) latch; new values valid before (524,799).
- rst_n low at MUL cycle 30 for one cycle: all outputs 0, frame_ready=0; the next frame latch produces correct values.
- Saturation: edge with E(0,0)=-500000 and dx=1023 stepped 479 lines: the output clamps at -524288 and never wraps positive.

Source files
------------

// File: rtl/tri_setup_pkg.sv
// Shared constants, FSM state type, edge table and saturation helper for
// the triangle setup engine.
package tri_setup_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int C_W      = 10;
  localparam int E_W      = 20;
  localparam int B_W      = 22;
  localparam int D_W      = C_W + 1;    // edge delta width
  localparam int P_W      = C_W + D_W;  // product width
  localparam int S_W      = 23;         // pre-saturation edge sum width

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_MUL,
    S_ACC,
    S_LOAD
  } state_t;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } edge_pair_t;

  // Edges 0..2 belong to triangle 1, edges 3..5 to triangle 2.
  function automatic edge_pair_t edge_pair(input logic [2:0] idx);
    case (idx)
      3'd0:    return '{a: 2'd0, b: 2'd1};
      3'd1:    return '{a: 2'd1, b: 2'd2};
      3'd2:    return '{a: 2'd2, b: 2'd0};
      3'd3:    return '{a: 2'd0, b: 2'd2};
      3'd4:    return '{a: 2'd2, b: 2'd3};
      default: return '{a: 2'd3, b: 2'd0};
    endcase
  endfunction

  localparam logic signed [S_W-1:0] E_MAX_S = S_W'(2**(E_W-1) - 1);
  localparam logic signed [S_W-1:0] E_MIN_S = S_W'(-(2**(E_W-1)));

  // Clamp a wide edge value into the E_W output range.
  function automatic logic signed [E_W-1:0] sat_e(input logic signed [S_W-1:0] v);
    if (v > E_MAX_S)      return {1'b0, {(E_W-1){1'b1}}};
    else if (v < E_MIN_S) return {1'b1, {(E_W-1){1'b0}}};
    else                  return v[E_W-1:0];
  endfunction

endpackage

// File: rtl/tri_setup_if.sv
// Bundle of scan position, vertex/barycentric inputs and rasterizer setup outputs.
interface tri_setup_if;
  import tri_setup_pkg::*;

  logic [9:0]            x, y;
  logic signed [C_W-1:0] vx0, vx1, vx2, vx3;
  logic signed [C_W-1:0] vy0, vy1, vy2, vy3;
  logic [B_W-1:0]        bar_iy0, bar_iz0, bar2_iy0, bar2_iz0;
  logic [B_W-1:0]        bar_iy_dy, bar_iz_dy, bar2_iy_dy, bar2_iz_dy;
  logic [B_W-1:0]        bar_iy_dx_in, bar_iz_dx_in, bar2_iy_dx_in, bar2_iz_dx_in;
  logic signed [E_W-1:0] y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3;
  logic signed [E_W-1:0] e0_init_t1, e1_init_t1, e2_init_t1;
  logic signed [E_W-1:0] e0_init_t2, e1_init_t2, e2_init_t2;
  logic [B_W-1:0]        bar_iy, bar_iz, bar2_iy, bar2_iz;
  logic [B_W-1:0]        bar_iy_dx, bar_iz_dx, bar2_iy_dx, bar2_iz_dx;
  logic                  frame_ready;

  modport master (
    output x, y, vx0, vx1, vx2, vx3, vy0, vy1, vy2, vy3,
           bar_iy0, bar_iz0, bar2_iy0, bar2_iz0,
           bar_iy_dy, bar_iz_dy, bar2_iy_dy, bar2_iz_dy,
           bar_iy_dx_in, bar_iz_dx_in, bar2_iy_dx_in, bar2_iz_dx_in,
    input  y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3,
           e0_init_t1, e1_init_t1, e2_init_t1, e0_init_t2, e1_init_t2, e2_init_t2,
           bar_iy, bar_iz, bar2_iy, bar2_iz,
           bar_iy_dx, bar_iz_dx, bar2_iy_dx, bar2_iz_dx, frame_ready
  );

  modport slave (
    input  x, y, vx0, vx1, vx2, vx3, vy0, vy1, vy2, vy3,
           bar_iy0, bar_iz0, bar2_iy0, bar2_iz0,
           bar_iy_dy, bar_iz_dy, bar2_iy_dy, bar2_iz_dy,
           bar_iy_dx_in, bar_iz_dx_in, bar2_iy_dx_in, bar2_iz_dx_in,
    output y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3,
           e0_init_t1, e1_init_t1, e2_init_t1, e0_init_t2, e1_init_t2, e2_init_t2,
           bar_iy, bar_iz, bar2_iy, bar2_iz,
           bar_iy_dx, bar_iz_dx, bar2_iy_dx, bar2_iz_dx, frame_ready
  );
endinterface

// File: rtl/tri_setup_mul.sv
// Signed radix-2 shift-add multiplier: one multiplier bit per cycle, the
// start cycle consumes bit 0, the sign bit is subtracted on the last cycle.
module seq_mul_s
  import tri_setup_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic signed [C_W-1:0] a,
  input  logic signed [D_W-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic signed [P_W-1:0] p
);

  logic signed [P_W-1:0] mcand;
  logic [D_W-1:0]        mplier;
  logic [3:0]            cnt;
  logic                  last;

  assign last = (cnt == 4'(D_W-1));

  // Iterate over the multiplier bits, accumulating shifted multiplicands.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      p      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        p      <= b[0] ? P_W'(a) : '0;
        mcand  <= P_W'(a) <<< 1;
        mplier <= b >> 1;
        cnt    <= 4'd1;
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) p <= last ? p - mcand : p + mcand;
        mcand  <= mcand <<< 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 4'd1;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tri_setup.sv
// Per-frame edge/barycentric setup with incremental per-line stepping.
module tri_setup
  import tri_setup_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  tri_setup_if.slave bus
);

  state_t                state;
  logic [2:0]            edge_idx;
  logic                  prod_sel;   // 0: xa*dy, 1: ya*dx
  logic                  mul_start, mul_busy, mul_done;
  logic signed [P_W-1:0] mul_p, p0;
  logic signed [C_W-1:0] mul_a;
  logic signed [D_W-1:0] mul_b;
  logic                  frame_ready;

  logic signed [C_W-1:0] vx_in [4], vy_in [4], vx_l [4], vy_l [4];
  logic [B_W-1:0]        b0_in [4], bdy_in [4], bdx_in [4];
  logic [B_W-1:0]        b0_l [4], bdy_l [4], bdx_l [4];
  logic signed [E_W-1:0] e_q [6], ysv_q [4];
  logic [B_W-1:0]        bar_q [4], bdx_q [4];
  edge_pair_t            pr [6];
  logic signed [D_W-1:0] e_dx [6], e_dy [6];

  assign vx_in  = '{bus.vx0, bus.vx1, bus.vx2, bus.vx3};
  assign vy_in  = '{bus.vy0, bus.vy1, bus.vy2, bus.vy3};
  assign b0_in  = '{bus.bar_iy0, bus.bar_iz0, bus.bar2_iy0, bus.bar2_iz0};
  assign bdy_in = '{bus.bar_iy_dy, bus.bar_iz_dy, bus.bar2_iy_dy, bus.bar2_iz_dy};
  assign bdx_in = '{bus.bar_iy_dx_in, bus.bar_iz_dx_in, bus.bar2_iy_dx_in, bus.bar2_iz_dx_in};

  // Edge deltas from the latched vertices; stable whenever stepping is enabled.
  // NOTE: every always_comb output is assigned on every path, so no latch.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      pr[k]   = edge_pair(3'(k));
      e_dx[k] = D_W'(vx_l[pr[k].b]) - D_W'(vx_l[pr[k].a]);
      e_dy[k] = D_W'(vy_l[pr[k].b]) - D_W'(vy_l[pr[k].a]);
    end
  end

  assign mul_a = prod_sel ? vy_l[pr[edge_idx].a] : vx_l[pr[edge_idx].a];
  assign mul_b = prod_sel ? e_dx[edge_idx]       : e_dy[edge_idx];

  seq_mul_s u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Frame setup FSM plus per-line stepping; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      edge_idx    <= '0;
      prod_sel    <= 1'b0;
      mul_start   <= 1'b0;
      p0          <= '0;
      frame_ready <= 1'b0;
      // NOTE: these arrays are plain flop banks rather than RAM, so they
      // are cleared like any other register.
      vx_l  <= '{default: '0};
      vy_l  <= '{default: '0};
      b0_l  <= '{default: '0};
      bdy_l <= '{default: '0};
      bdx_l <= '{default: '0};
      e_q   <= '{default: '0};
      ysv_q <= '{default: '0};
      bar_q <= '{default: '0};
      bdx_q <= '{default: '0};
    end else begin
      mul_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.y == 10'(V_ACTIVE) && bus.x == '0) begin
            state <= S_LATCH;
          end else if (frame_ready && bus.y < 10'(V_ACTIVE) && bus.x == 10'(H_ACTIVE)) begin
            for (int k = 0; k < 6; k++)
              e_q[k] <= sat_e(S_W'(e_q[k]) - S_W'(e_dx[k]));
            for (int k = 0; k < 4; k++)
              bar_q[k] <= bar_q[k] + bdy_l[k];
          end
        end
        S_LATCH: begin
          vx_l        <= vx_in;
          vy_l        <= vy_in;
          b0_l        <= b0_in;
          bdy_l       <= bdy_in;
          bdx_l       <= bdx_in;
          frame_ready <= 1'b0;
          edge_idx    <= '0;
          prod_sel    <= 1'b0;
          mul_start   <= 1'b1;
          state       <= S_MUL;
        end
        S_MUL: begin
          if (mul_done && !mul_busy) begin
            if (!prod_sel) begin
              p0        <= mul_p;
              prod_sel  <= 1'b1;
              mul_start <= 1'b1;
            end else begin
              state <= S_ACC;
            end
          end
        end
        S_ACC: begin
          // E(0,0) = ya*dx - xa*dy; the multiplier still holds ya*dx.
          e_q[edge_idx] <= sat_e(S_W'(mul_p) - S_W'(p0));
          if (edge_idx == 3'd5) begin
            state <= S_LOAD;
          end else begin
            edge_idx  <= edge_idx + 3'd1;
            prod_sel  <= 1'b0;
            mul_start <= 1'b1;
            state     <= S_MUL;
          end
        end
        S_LOAD: begin
          bar_q <= b0_l;
          bdx_q <= bdx_l;
          for (int k = 0; k < 4; k++)
            ysv_q[k] <= E_W'(vy_l[k]);
          frame_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.e0_init_t1  = e_q[0];
  assign bus.e1_init_t1  = e_q[1];
  assign bus.e2_init_t1  = e_q[2];
  assign bus.e0_init_t2  = e_q[3];
  assign bus.e1_init_t2  = e_q[4];
  assign bus.e2_init_t2  = e_q[5];
  assign bus.bar_iy      = bar_q[0];
  assign bus.bar_iz      = bar_q[1];
  assign bus.bar2_iy     = bar_q[2];
  assign bus.bar2_iz     = bar_q[3];
  assign bus.bar_iy_dx   = bdx_q[0];
  assign bus.bar_iz_dx   = bdx_q[1];
  assign bus.bar2_iy_dx  = bdx_q[2];
  assign bus.bar2_iz_dx  = bdx_q[3];
  assign bus.y_screen_v0 = ysv_q[0];
  assign bus.y_screen_v1 = ysv_q[1];
  assign bus.y_screen_v2 = ysv_q[2];
  assign bus.y_screen_v3 = ysv_q[3];
  assign bus.frame_ready = frame_ready;

endmodule

// File: tb/tb_tri_setup.sv
// Self-checking bench for tri_setup: a reference model pushes expected
// snapshots into a scoreboard that is popped when the DUT output is due.
module tb_tri_setup;
  import tri_setup_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tri_setup_if bus();

  tri_setup dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0][E_W-1:0] e;
    logic [3:0][B_W-1:0] bar;
  } snap_t;

  snap_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  // Stimulus inputs and model state.
  int             in_vx[4], in_vy[4];
  logic [B_W-1:0] in_b0[4], in_bdy[4], in_bdx[4];
  int             m_e[6], m_dx[6], m_ys[4];
  logic [B_W-1:0] m_bar[4], m_bdy[4], m_bdx[4];
  int             ea[6] = '{0, 1, 2, 0, 2, 3};
  int             eb[6] = '{1, 2, 0, 2, 3, 0};

  // Observed outputs gathered into arrays.
  int             obs_e[6], obs_ys[4];
  logic [B_W-1:0] obs_b[4], obs_bdx[4];

  always_comb begin
    obs_e   = '{int'(bus.e0_init_t1), int'(bus.e1_init_t1), int'(bus.e2_init_t1),
                int'(bus.e0_init_t2), int'(bus.e1_init_t2), int'(bus.e2_init_t2)};
    obs_ys  = '{int'(bus.y_screen_v0), int'(bus.y_screen_v1),
                int'(bus.y_screen_v2), int'(bus.y_screen_v3)};
    obs_b   = '{bus.bar_iy, bus.bar_iz, bus.bar2_iy, bus.bar2_iz};
    obs_bdx = '{bus.bar_iy_dx, bus.bar_iz_dx, bus.bar2_iy_dx, bus.bar2_iz_dx};
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_inputs();
    bus.vx0 = C_W'(in_vx[0]); bus.vx1 = C_W'(in_vx[1]);
    bus.vx2 = C_W'(in_vx[2]); bus.vx3 = C_W'(in_vx[3]);
    bus.vy0 = C_W'(in_vy[0]); bus.vy1 = C_W'(in_vy[1]);
    bus.vy2 = C_W'(in_vy[2]); bus.vy3 = C_W'(in_vy[3]);
    bus.bar_iy0 = in_b0[0];  bus.bar_iz0 = in_b0[1];
    bus.bar2_iy0 = in_b0[2]; bus.bar2_iz0 = in_b0[3];
    bus.bar_iy_dy = in_bdy[0];  bus.bar_iz_dy = in_bdy[1];
    bus.bar2_iy_dy = in_bdy[2]; bus.bar2_iz_dy = in_bdy[3];
    bus.bar_iy_dx_in = in_bdx[0];  bus.bar_iz_dx_in = in_bdx[1];
    bus.bar2_iy_dx_in = in_bdx[2]; bus.bar2_iz_dx_in = in_bdx[3];
  endtask

  function automatic int clamp_e(input int v);
    if (v > 524287)  return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  // Edge value at the origin is the 2D cross product ya*xb - xa*yb.
  task automatic model_latch();
    for (int k = 0; k < 6; k++) begin
      m_dx[k] = in_vx[eb[k]] - in_vx[ea[k]];
      m_e[k]  = clamp_e(in_vy[ea[k]] * in_vx[eb[k]] - in_vx[ea[k]] * in_vy[eb[k]]);
    end
    for (int k = 0; k < 4; k++) begin
      m_bar[k] = in_b0[k];
      m_bdy[k] = in_bdy[k];
      m_bdx[k] = in_bdx[k];
      m_ys[k]  = in_vy[k];
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 6; k++) m_e[k] = clamp_e(m_e[k] - m_dx[k]);
    for (int k = 0; k < 4; k++) m_bar[k] = m_bar[k] + m_bdy[k];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin m_e[k] = 0; m_dx[k] = 0; end
    for (int k = 0; k < 4; k++) begin
      m_bar[k] = '0; m_bdy[k] = '0; m_bdx[k] = '0; m_ys[k] = 0;
    end
  endtask

  function automatic snap_t make_snap();
    snap_t s;
    for (int k = 0; k < 6; k++) s.e[k] = E_W'(m_e[k]);
    for (int k = 0; k < 4; k++) s.bar[k] = m_bar[k];
    return s;
  endfunction

  task automatic check_snap(input string tag, input snap_t s);
    for (int k = 0; k < 6; k++)
      check($sformatf("%s e%0d", tag, k), obs_e[k], $signed(s.e[k]));
    for (int k = 0; k < 4; k++)
      check($sformatf("%s bar%0d", tag, k), obs_b[k], s.bar[k]);
  endtask

  task automatic check_static(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s bar_dx%0d", tag, k), obs_bdx[k], m_bdx[k]);
      check($sformatf("%s y_screen%0d", tag, k), obs_ys[k], m_ys[k]);
    end
    check({tag, " frame_ready"}, bus.frame_ready, 1);
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 6; k++) check($sformatf("%s e%0d", tag, k), obs_e[k], 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s bar%0d", tag, k), obs_b[k], 0);
      check($sformatf("%s bar_dx%0d", tag, k), obs_bdx[k], 0);
      check($sformatf("%s y_screen%0d", tag, k), obs_ys[k], 0);
    end
    check({tag, " frame_ready"}, bus.frame_ready, 0);
  endtask

  // Trigger the frame latch at (V_ACTIVE, 0) and wait (bounded) for frame_ready.
  task automatic do_frame(input string tag);
    snap_t s;
    int n;
    bus.y = 10'(V_ACTIVE);
    bus.x = '0;
    model_latch();
    sb.push_back(make_snap());
    tick();
    bus.x = 10'd1;
    tick();
    check({tag, " frame_ready low"}, bus.frame_ready, 0);
    n = 0;
    while (!bus.frame_ready && n < 400) begin
      tick();
      n++;
    end
    check({tag, " frame_ready high"}, bus.frame_ready, 1);
    check({tag, " setup within 160 cycles"}, (n <= 160), 1);
    s = sb.pop_front();
    check_snap(tag, s);
    check_static(tag);
  endtask

  // Issue the step at x==H_ACTIVE for line yy and check it is held afterwards.
  task automatic do_line(input int yy, input bit to_799);
    snap_t s;
    bus.y = 10'(yy);
    bus.x = 10'(H_ACTIVE);
    model_step();
    sb.push_back(make_snap());
    tick();
    bus.x = 10'(H_ACTIVE + 1);
    s = sb.pop_front();
    check_snap($sformatf("y%0d x641", yy), s);
    tick();
    bus.x = 10'd700;
    tick();
    check_snap($sformatf("y%0d x700", yy), s);
    if (to_799) begin
      bus.x = 10'd799;
      tick();
      check_snap($sformatf("y%0d x799", yy), s);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    in_vx  = '{100, 200, 100, 150};
    in_vy  = '{100, 100, 200, 250};
    in_b0  = '{22'h40000, 22'h12345, 22'h3FFF00, 22'h0};
    in_bdy = '{22'h100, 22'h3FFFFF, 22'h2000, 22'h1};
    in_bdx = '{22'h10, 22'h20, 22'h30, 22'h40};
    drive_inputs();
    bus.x = '0;
    bus.y = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    check_zero("reset");

    // Frame 1: reference triangle.
    do_frame("frame1");
    check("frame1 e0_t1 const", obs_e[0], 10000);
    check("frame1 e1_t1 const", obs_e[1], -30000);
    check("frame1 e2_t1 const", obs_e[2], 10000);

    for (int yy = 0; yy < V_ACTIVE; yy++) begin
      do_line(yy, yy == 0);
      check($sformatf("y%0d bar_iy const", yy), obs_b[0], 22'(32'h40000 + (yy + 1) * 32'h100));
      if (yy == 0) begin
        check("line0 e0_t1 const", obs_e[0], 9900);
        check("line0 e1_t1 const", obs_e[1], -29900);
        check("line0 e2_t1 const", obs_e[2], 10000);
      end
      if (yy == 200) begin
        // New scene for the next frame; must not disturb the current one.
        in_vx  = '{-512, 511, 0, 100};
        in_vy  = '{-488, -488, 0, -300};
        in_bdy = '{22'h200, 22'h3, 22'h3FF000, 22'h77};
        in_b0  = '{22'h1, 22'h2, 22'h3, 22'h4};
        in_bdx = '{22'h111, 22'h222, 22'h333, 22'h3FFFFF};
        drive_inputs();
      end
    end

    // Vertical blank: a line-step position must not step.
    begin
      snap_t s;
      sb.push_back(make_snap());
      bus.y = 10'd490;
      bus.x = 10'(H_ACTIVE);
      tick();
      bus.x = 10'd641;
      tick();
      s = sb.pop_front();
      check_snap("vblank hold", s);
    end

    // Frame 2: saturating edge (E0 starts at -499224 with dx=1023).
    do_frame("frame2");
    for (int yy = 0; yy < V_ACTIVE - 1; yy++) do_line(yy, 1'b0);
    check("sat floor e0_t1", obs_e[0], -524288);

    // Frame 3: reset in the middle of the multiply phase.
    in_vx = '{10, 300, -200, 400};
    in_vy = '{20, -50, 150, 400};
    for (int k = 0; k < 4; k++) begin
      in_b0[k]  = B_W'($urandom);
      in_bdy[k] = B_W'($urandom);
      in_bdx[k] = B_W'($urandom);
    end
    drive_inputs();
    bus.y = 10'(V_ACTIVE);
    bus.x = '0;
    tick();
    bus.x = 10'd1;
    tick();
    repeat (28) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    sb.delete();
    check_zero("mid-mul reset");
    tick();
    check_zero("after reset");
    do_frame("frame3");
    for (int yy = 0; yy < 8; yy++) do_line(yy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
